// File: rtl/muldiv_unit.sv
// Purpose : iterative RISC-V M-extension multiply/divide unit (shift-add multiply, restoring divide).
// Latency : done pulses 33 cycles after the accepting edge's cycle (32 iterations); divide-by-zero
//           finishes in the cycle right after acceptance.
// Backpr. : no handshake; start is ignored while busy=1, and is accepted in IDLE or in the DONE cycle.
// Optional: define MULDIV_SIGNED_EN to give MULH/MULHSU/DIV/REM signed RISC-V semantics; otherwise
//           001/010 run as MULHU, 100 as DIVU, 110 as REMU.
// Ports   : clk, rst_n (async active-low) | start, op[2:0] (funct3), opA, opB (request)
//           busy (iterating), done (1-cycle result pulse), result, divZero (divide by zero flag)
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] opA,
   input  logic [DATA_WIDTH-1:0] opB,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  divZero
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    hi_q, lo_q, b_q;      // hi:lo = product / remainder:quotient, b = multiplicand/divisor
   logic [2:0]      op_q;
   logic            neg_p_q;              // negate product or quotient
   logic            neg_r_q;              // negate remainder
   logic [CW-1:0]   cnt_q;
   logic            dz_q;
   logic [W-1:0]    result_q;

   logic            accept, div_zero_req, last_iter;
   logic            sign_a, sign_b, a_neg, b_neg;
   logic [W-1:0]    mag_a, mag_b;
   logic [W:0]      mul_sum;
   logic [W:0]      div_shift;
   logic            div_ge;
   logic [W-1:0]    hi_nxt, lo_nxt;
   logic [2*W-1:0]  prod;
   logic [W-1:0]    quo, rem, fin;

   assign accept       = start && (state != RUN);
   assign div_zero_req = op[2] && (opB == '0);
   assign last_iter    = (cnt_q == CW'(W - 1));

   // Which operands are treated as two's complement; all-zero in the unsigned-only build,
   // which folds the magnitude and sign-correction muxes away.
   always_comb begin
      sign_a = 1'b0;
      sign_b = 1'b0;
`ifdef MULDIV_SIGNED_EN
      case (op)
         3'b001, 3'b100, 3'b110: begin
            sign_a = 1'b1;
            sign_b = 1'b1;
         end
         3'b010: sign_a = 1'b1;   // MULHSU: rs1 signed, rs2 unsigned
         default: ;
      endcase
`endif
   end

   assign a_neg = sign_a && opA[W-1];
   assign b_neg = sign_b && opB[W-1];
   assign mag_a = a_neg ? ('0 - opA) : opA;
   assign mag_b = b_neg ? ('0 - opB) : opB;

   // One iteration of either datapath plus the final sign fix-up applied on the last one.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_shift = {hi_q, lo_q[W-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      if (op_q[2]) begin
         // Partial remainder is always < divisor, so div_shift < 2*divisor and the
         // difference fits in W bits.
         hi_nxt = div_ge ? (div_shift[W-1:0] - b_q) : div_shift[W-1:0];
         lo_nxt = {lo_q[W-2:0], div_ge};
      end else begin
         hi_nxt = mul_sum[W:1];
         lo_nxt = {mul_sum[0], lo_q[W-1:1]};
      end
      prod = {hi_nxt, lo_nxt};
      if (neg_p_q) begin
         prod = '0 - prod;
      end
      quo = neg_p_q ? ('0 - lo_nxt) : lo_nxt;
      rem = neg_r_q ? ('0 - hi_nxt) : hi_nxt;
      if (op_q[2]) begin
         fin = op_q[1] ? rem : quo;
      end else begin
         fin = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = div_zero_req ? DONE : RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         op_q     <= '0;
         neg_p_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         cnt_q    <= '0;
         dz_q     <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         op_q    <= op;
         cnt_q   <= '0;
         neg_p_q <= a_neg ^ b_neg;
         neg_r_q <= a_neg;
         hi_q    <= '0;
         if (div_zero_req) begin
            // Architectural divide-by-zero results use the raw operand, not its magnitude.
            dz_q     <= 1'b1;
            result_q <= op[1] ? opA : '1;
         end else begin
            dz_q <= 1'b0;
            if (op[2]) begin
               lo_q <= mag_a;     // dividend shifts out as quotient shifts in
               b_q  <= mag_b;
            end else begin
               lo_q <= mag_b;     // multiplier shifts out as low product shifts in
               b_q  <= mag_a;
            end
         end
      end else if (state == RUN) begin
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
         cnt_q <= cnt_q + 1'b1;
         if (last_iter) begin
            result_q <= fin;
         end
      end
   end

   assign busy    = (state == RUN);
   assign done    = (state == DONE);
   assign divZero = (state == DONE) && dz_q;
   assign result  = result_q;

endmodule
